// File: rtl/mode_pkg.sv
// mode_pkg: main-mode encodings and controller state shared by the mode arbiter and the drawers.
package mode_pkg;
  localparam logic [1:0] MODE_WELCOME = 2'b01;
  localparam logic [1:0] MODE_CALC = 2'b10;
  localparam logic [1:0] MODE_GRAPH = 2'b11;
  localparam int FCNT_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DROP} state_t;
  function automatic logic [1:0] mode_owner(input logic [1:0] mode);
    return mode - 2'd1;
  endfunction
  function automatic logic mode_legal(input logic [1:0] mode);
    return mode == MODE_WELCOME || mode == MODE_CALC || mode == MODE_GRAPH;
  endfunction
endpackage

// File: rtl/btn_hold_detector.sv
// btn_hold_detector: one-cycle pulse once a level has been high for HOLD consecutive cycles.
module btn_hold_detector #(
  parameter int HOLD = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic clr,
  input  logic en,
  output logic hold_hit
);
  localparam int W = $clog2(HOLD + 1);
  logic [W-1:0] cnt;
  // Saturating at HOLD means the HOLD-1 match happens once per press, so the pulse re-arms only on release.
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !level) begin
      cnt <= '0;
      hold_hit <= 1'b0;
    end else if (en) begin
      cnt <= (cnt == W'(HOLD)) ? cnt : cnt + 1'b1;
      hold_hit <= cnt == W'(HOLD - 1);
    end else begin
      hold_hit <= 1'b0;
    end
  end
endmodule

// File: rtl/main_mode_controller.sv
// main_mode_controller: arbitrates main-mode switches, committing them on frame boundaries behind a blanking window.
module main_mode_controller
  import mode_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int SETTLE_FRAMES = 2,
  parameter int HOME_HOLD_CYCLES = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     home_btn,
  input  logic [NUM_CLIENTS-1:0]   mode_req,
  input  logic [2*NUM_CLIENTS-1:0] mode_target,
  output logic [NUM_CLIENTS-1:0]   mode_ack,
  output logic [1:0]               current_main_mode,
  output logic                     mode_blank
);
  state_t state, state_n;
  logic [1:0] mode_n, target, target_n, grant, grant_n, own, req_t;
  logic internal, internal_n, blank_n, req_v, grant_req, hold_hit, home_req;
  logic [NUM_CLIENTS-1:0] ack_n;
  logic [FCNT_W-1:0] fcnt, fcnt_n;

  btn_hold_detector #(.HOLD(HOME_HOLD_CYCLES)) u_hold (
    .clk(clk),
    .rst_n(rst_n),
    .level(home_btn),
    .clr(1'b0),
    .en(1'b1),
    .hold_hit(hold_hit)
  );

  always_comb begin
    own = mode_owner(current_main_mode);
    req_v = 1'b0;
    req_t = 2'b00;
    grant_req = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (own == 2'(i)) begin
        req_v = mode_req[i];
        req_t = mode_target[2*i +: 2];
      end
      if (grant == 2'(i)) grant_req = mode_req[i];
    end
    home_req = hold_hit && current_main_mode != MODE_WELCOME;
    state_n = state;
    mode_n = current_main_mode;
    ack_n = '0;
    blank_n = mode_blank;
    target_n = target;
    grant_n = grant;
    internal_n = internal;
    fcnt_n = fcnt;
    case (state)
      ST_IDLE: begin
        if (home_req) begin
          target_n = MODE_WELCOME;
          internal_n = 1'b1;
          blank_n = 1'b1;
          fcnt_n = '0;
          state_n = ST_BLANK;
        end else if (req_v) begin
          grant_n = own;
          internal_n = 1'b0;
          if (mode_legal(req_t) && req_t != current_main_mode) begin
            target_n = req_t;
            blank_n = 1'b1;
            fcnt_n = '0;
            state_n = ST_BLANK;
          end else begin
            ack_n = NUM_CLIENTS'(1) << own;
            state_n = ST_DROP;
          end
        end
      end
      ST_BLANK: begin
        if (frame_start) begin
          fcnt_n = fcnt + 1'b1;
          if (fcnt == FCNT_W'(SETTLE_FRAMES - 1)) begin
            mode_n = target;
            ack_n = internal ? '0 : NUM_CLIENTS'(1) << grant;
            state_n = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (internal ? !home_btn : !grant_req) begin
          blank_n = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      current_main_mode <= MODE_WELCOME;
      mode_ack <= '0;
      mode_blank <= 1'b0;
      target <= MODE_WELCOME;
      grant <= 2'd0;
      internal <= 1'b0;
      fcnt <= '0;
    end else begin
      state <= state_n;
      current_main_mode <= mode_n;
      mode_ack <= ack_n;
      mode_blank <= blank_n;
      target <= target_n;
      grant <= grant_n;
      internal <= internal_n;
      fcnt <= fcnt_n;
    end
  end
endmodule

// File: tb/tb_main_mode_controller.sv
// tb_main_mode_controller: randomized scoreboard bench; expected output changes are queued and matched by a monitor.
module tb_main_mode_controller;
  localparam int FP = 100;
  localparam int SETTLE = 2;
  localparam int HOLD = 8;

  typedef struct {
    int lo;
    int hi;
    logic [5:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic home_btn = 1'b0;
  logic [2:0] mode_req = '0;
  logic [5:0] mode_target = '0;
  logic [2:0] mode_ack;
  logic [1:0] current_main_mode;
  logic mode_blank;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int phase = 0;
  logic [1:0] m_mode = 2'b01;
  bit mon_on = 1'b0;
  logic [5:0] prev, cur_obs;
  ev_t exp_ev;
  ev_t q[$];

  main_mode_controller #(
    .NUM_CLIENTS(3),
    .SETTLE_FRAMES(SETTLE),
    .HOME_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .home_btn(home_btn),
    .mode_req(mode_req),
    .mode_target(mode_target),
    .mode_ack(mode_ack),
    .current_main_mode(current_main_mode),
    .mode_blank(mode_blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d required finish", cyc);
    $fatal(1);
  end

  // Any change of {ack, mode, blank} must match the next queued expectation, inside its edge window.
  always @(negedge clk) begin
    if (mon_on) begin
      cur_obs = {mode_ack, current_main_mode, mode_blank};
      if (cur_obs !== prev) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got ack=%b mode=%b blank=%b required no change",
                   cyc, cur_obs[5:3], cur_obs[2:1], cur_obs[0]);
        end else begin
          exp_ev = q.pop_front();
          if (cur_obs !== exp_ev.val || cyc < exp_ev.lo || cyc > exp_ev.hi) begin
            fails++;
            $display("FAIL output_event got ack=%b mode=%b blank=%b at cyc %0d required ack=%b mode=%b blank=%b at cyc %0d..%0d",
                     cur_obs[5:3], cur_obs[2:1], cur_obs[0], cyc,
                     exp_ev.val[5:3], exp_ev.val[2:1], exp_ev.val[0], exp_ev.lo, exp_ev.hi);
          end
        end
        prev = cur_obs;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    phase = (phase + 1) % FP;
    frame_start = (phase == 0);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  function automatic logic [2:0] oh(int c);
    return 3'b001 << c;
  endfunction

  task automatic expect_ev(int lo, int hi, logic [2:0] a, logic [1:0] m, logic b);
    q.push_back('{lo, hi, {a, m, b}});
  endtask

  task automatic do_client(int c, logic [1:0] tgt, bit early, bit align);
    int t, f, n, dk, own;
    own = int'(m_mode) - 1;
    if (align) do tick(); while (!frame_start);
    mode_target = 6'($urandom);
    mode_target[2*c +: 2] = tgt;
    mode_req[c] = 1'b1;
    t = cyc + 1;
    if (c != own) begin
      idle($urandom_range(150, 250));
      mode_req[c] = 1'b0;
      idle(2);
      return;
    end
    if (tgt == 2'b00 || tgt == m_mode) begin
      expect_ev(t, t, oh(c), m_mode, 1'b0);
      expect_ev(t + 1, t + 1, 3'b000, m_mode, 1'b0);
      idle($urandom_range(2, 5));
      mode_req[c] = 1'b0;
      idle(2);
      return;
    end
    expect_ev(t, t, 3'b000, m_mode, 1'b1);
    n = 0;
    dk = $urandom_range(1, 30);
    // Only pulses sampled after the request edge count toward the settle window.
    for (int k = 1; n < SETTLE; k++) begin
      tick();
      if (early && k == dk) mode_req[c] = 1'b0;
      if (frame_start) n++;
    end
    f = cyc + 1;
    expect_ev(f, f, oh(c), tgt, 1'b1);
    m_mode = tgt;
    if (early) begin
      expect_ev(f + 1, f + 1, 3'b000, tgt, 1'b0);
      idle(2);
      return;
    end
    expect_ev(f + 1, f + 1, 3'b000, tgt, 1'b1);
    idle($urandom_range(2, 5));
    mode_req[c] = 1'b0;
    expect_ev(cyc + 1, cyc + 1, 3'b000, tgt, 1'b0);
    idle(2);
  endtask

  task automatic do_home();
    int h, f, n;
    while (phase != 5) tick();
    home_btn = 1'b1;
    h = cyc + 1;
    if (m_mode == 2'b01) begin
      idle($urandom_range(12, 20));
      home_btn = 1'b0;
      idle(2);
      return;
    end
    expect_ev(h + HOLD - 1, h + HOLD, 3'b000, m_mode, 1'b1);
    idle(HOLD + 2);
    n = 0;
    while (n < SETTLE) begin
      tick();
      if (frame_start) n++;
    end
    f = cyc + 1;
    expect_ev(f, f, 3'b000, 2'b01, 1'b1);
    m_mode = 2'b01;
    idle($urandom_range(2, 5));
    home_btn = 1'b0;
    expect_ev(cyc + 1, cyc + 1, 3'b000, 2'b01, 1'b0);
    idle(2);
  endtask

  task automatic do_reset_in_blank();
    mode_target = 6'b00_00_10;
    mode_req[0] = 1'b1;
    expect_ev(cyc + 1, cyc + 1, 3'b000, m_mode, 1'b1);
    idle($urandom_range(10, 50));
    rst_n = 1'b0;
    mode_req = '0;
    expect_ev(cyc + 1, cyc + 1, 3'b000, 2'b01, 1'b0);
    m_mode = 2'b01;
    idle(3);
    rst_n = 1'b1;
    idle(3 * FP);
  endtask

  initial begin
    int r, c;
    idle(3);
    checks++;
    if (current_main_mode !== 2'b01) begin
      fails++;
      $display("FAIL reset_mode got %b required 01", current_main_mode);
    end
    checks++;
    if (mode_ack !== 3'b000) begin
      fails++;
      $display("FAIL reset_ack got %b required 000", mode_ack);
    end
    checks++;
    if (mode_blank !== 1'b0) begin
      fails++;
      $display("FAIL reset_blank got %b required 0", mode_blank);
    end
    rst_n = 1'b1;
    prev = {3'b000, 2'b01, 1'b0};
    mon_on = 1'b1;
    idle(2);
    do_client(0, 2'b10, 1'b0, 1'b0);
    mode_target = {2'b01, 2'b11, 2'b11};
    mode_req = 3'b101;
    idle(3 * FP);
    mode_req = '0;
    idle(2);
    do_client(1, 2'b11, 1'b0, 1'b0);
    do_home();
    do_client(0, 2'b01, 1'b0, 1'b0);
    do_client(0, 2'b00, 1'b0, 1'b0);
    do_client(0, 2'b11, 1'b0, 1'b1);
    do_client(2, 2'b10, 1'b1, 1'b0);
    do_home();
    do_reset_in_blank();
    repeat (24) begin
      idle($urandom_range(0, 40));
      r = $urandom_range(0, 9);
      if (r < 2) do_home();
      else begin
        c = (r < 7) ? int'(m_mode) - 1 : int'($urandom_range(0, 2));
        do_client(c, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      end
    end
    idle(5);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got %0d required 0", q.size());
    end
    checks++;
    if (current_main_mode !== m_mode) begin
      fails++;
      $display("FAIL final_mode got %b required %b", current_main_mode, m_mode);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
